ycc_to_rgb_raster: RTL

Downstream of the decoder top. Consumes one decoded 8x8 Y/Cb/Cr block triplet per handshake, as produced alongside valid_out_Buffer. Converts each sample position to 8-bit RGB using fixed-point BT.601 (JFIF) coefficients with rounding and clamping. Streams 64 pixels in raster order over a valid/ready interface to the frame writer.

---
 rtl/ycc_to_rgb_raster_pkg.sv | 32 +++
 rtl/ycc_to_rgb_raster_conv.sv | 55 +++++
 rtl/ycc_to_rgb_raster.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ycc_to_rgb_raster_pkg.sv
`default_nettype none
// =====================================================================
// Package : ycc_to_rgb_raster_pkg
// Purpose : Shared types and BT.601 colour coefficients for the raster stage.
// Rev     : 1.0
// =====================================================================
package ycc_to_rgb_raster_pkg;

   localparam int c_Q = 12;

   // Q8 JFIF coefficients (1.402, 0.344, 0.714, 1.772)
   localparam int c_CR_TO_R = 359;
   localparam int c_CB_TO_G = 88;
   localparam int c_CR_TO_G = 183;
   localparam int c_CB_TO_B = 454;

   typedef logic [7:0][7:0][c_Q-1:0] ycc_block_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } raster_state_t;

endpackage
`default_nettype wire

// File: rtl/ycc_to_rgb_raster_conv.sv
`default_nettype none
// =====================================================================
// Module  : ycc_pixel_conv
// Purpose : Combinational single-pixel Y/Cb/Cr to clamped 8-bit RGB.
// Rev     : 1.0
// =====================================================================
module ycc_pixel_conv
   import ycc_to_rgb_raster_pkg::*;
#(
   parameter int IN_W = 12,
   parameter int FRAC = 8
) (
   input  logic signed [IN_W-1:0] y,
   input  logic signed [IN_W-1:0] cb,
   input  logic signed [IN_W-1:0] cr,
   output rgb_pixel_t             pix
);

   localparam int c_W = IN_W + 10;

   localparam logic signed [c_W-1:0] c_K_CR_R = c_W'(c_CR_TO_R);
   localparam logic signed [c_W-1:0] c_K_CB_G = c_W'(c_CB_TO_G);
   localparam logic signed [c_W-1:0] c_K_CR_G = c_W'(c_CR_TO_G);
   localparam logic signed [c_W-1:0] c_K_CB_B = c_W'(c_CB_TO_B);
   localparam logic signed [c_W-1:0] c_HALF   = c_W'(1 << (FRAC - 1));
   localparam logic signed [c_W-1:0] c_LEVEL  = c_W'(128);
   localparam logic signed [c_W-1:0] c_MAX    = c_W'(255);

   logic signed [c_W-1:0] w_y, w_cb, w_cr;
   logic signed [c_W-1:0] w_r, w_g, w_b;

   function automatic logic [7:0] clamp8(input logic signed [c_W-1:0] v);
      if (v[c_W-1])
         return 8'd0;
      else if (v > c_MAX)
         return 8'd255;
      else
         return v[7:0];
   endfunction

   always_comb begin
      w_y  = {{(c_W-IN_W){y[IN_W-1]}},  y};
      w_cb = {{(c_W-IN_W){cb[IN_W-1]}}, cb};
      w_cr = {{(c_W-IN_W){cr[IN_W-1]}}, cr};
      // Rounded chroma terms; >>> floors so negative offsets round consistently
      w_r = w_y + ((c_K_CR_R * w_cr + c_HALF) >>> FRAC) + c_LEVEL;
      w_g = w_y - ((c_K_CB_G * w_cb + c_K_CR_G * w_cr + c_HALF) >>> FRAC) + c_LEVEL;
      w_b = w_y + ((c_K_CB_B * w_cb + c_HALF) >>> FRAC) + c_LEVEL;
      pix.r = clamp8(w_r);
      pix.g = clamp8(w_g);
      pix.b = clamp8(w_b);
   end

endmodule
`default_nettype wire

// File: rtl/ycc_to_rgb_raster.sv
`default_nettype none
// =====================================================================
// Module  : ycc_to_rgb_raster
// Purpose : Buffers an 8x8 Y/Cb/Cr triplet and streams 64 RGB pixels in
//           raster order. Define BLOCK_PINGPONG_EN for a double buffer.
// Rev     : 1.0
// =====================================================================
module ycc_to_rgb_raster
   import ycc_to_rgb_raster_pkg::*;
#(
   parameter int IN_W = 12,
   parameter int FRAC = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     blk_valid,
   output logic                     blk_ready,
   input  logic [7:0][7:0][IN_W-1:0] y_in,
   input  logic [7:0][7:0][IN_W-1:0] cb_in,
   input  logic [7:0][7:0][IN_W-1:0] cr_in,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic [7:0]               pix_r,
   output logic [7:0]               pix_g,
   output logic [7:0]               pix_b,
   output logic [2:0]               pix_row,
   output logic [2:0]               pix_col,
   output logic                     pix_last
);

`ifdef BLOCK_PINGPONG_EN
   localparam int c_NBUF = 2;
`else
   localparam int c_NBUF = 1;
`endif

   logic [7:0][7:0][IN_W-1:0] r_y_buf  [c_NBUF];
   logic [7:0][7:0][IN_W-1:0] r_cb_buf [c_NBUF];
   logic [7:0][7:0][IN_W-1:0] r_cr_buf [c_NBUF];

   logic [5:0]      r_cnt;
   logic            r_pix_valid;
   rgb_pixel_t      r_pix;
   logic [2:0]      r_row;
   logic [2:0]      r_col;
   logic            r_last;

   logic            w_capture;
   logic            w_load;
   logic            w_have_data;
   logic            w_advance;
   logic [IN_W-1:0] w_y_sel, w_cb_sel, w_cr_sel;
   rgb_pixel_t      w_pix;

   assign w_capture = blk_valid && blk_ready;
   assign w_load    = !r_pix_valid || pix_ready;
   assign w_advance = w_load && w_have_data;

`ifdef BLOCK_PINGPONG_EN
   logic [1:0] r_full;
   logic       r_rd_sel;
   logic       w_wr_sel;

   // Fill the streaming buffer only when it is empty, otherwise the spare one
   assign w_wr_sel    = r_full[r_rd_sel] ? ~r_rd_sel : r_rd_sel;
   assign w_have_data = r_full[r_rd_sel];
   assign blk_ready   = ~&r_full;

   assign w_y_sel  = r_y_buf[r_rd_sel][r_cnt[5:3]][r_cnt[2:0]];
   assign w_cb_sel = r_cb_buf[r_rd_sel][r_cnt[5:3]][r_cnt[2:0]];
   assign w_cr_sel = r_cr_buf[r_rd_sel][r_cnt[5:3]][r_cnt[2:0]];

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_y_buf[w_wr_sel]  <= y_in;
         r_cb_buf[w_wr_sel] <= cb_in;
         r_cr_buf[w_wr_sel] <= cr_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_full   <= 2'b00;
         r_rd_sel <= 1'b0;
      end else begin
         if (w_capture)
            r_full[w_wr_sel] <= 1'b1;
         // Buffer is released as soon as its last pixel enters the output register
         if (w_advance && (&r_cnt)) begin
            r_full[r_rd_sel] <= 1'b0;
            r_rd_sel         <= ~r_rd_sel;
         end
      end
   end
`else
   raster_state_t r_state;
   logic          r_blk_ready;

   assign w_have_data = (r_state == ST_STREAM);
   assign blk_ready   = r_blk_ready;

   assign w_y_sel  = r_y_buf[0][r_cnt[5:3]][r_cnt[2:0]];
   assign w_cb_sel = r_cb_buf[0][r_cnt[5:3]][r_cnt[2:0]];
   assign w_cr_sel = r_cr_buf[0][r_cnt[5:3]][r_cnt[2:0]];

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_y_buf[0]  <= y_in;
         r_cb_buf[0] <= cb_in;
         r_cr_buf[0] <= cr_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_blk_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_state     <= ST_STREAM;
                  r_blk_ready <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (w_advance && (&r_cnt))
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (r_pix_valid && pix_ready) begin
                  r_state     <= ST_IDLE;
                  r_blk_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_blk_ready <= 1'b1;
            end
         endcase
      end
   end
`endif

   ycc_pixel_conv #(
      .IN_W (IN_W),
      .FRAC (FRAC)
   ) u_conv (
      .y   (w_y_sel),
      .cb  (w_cb_sel),
      .cr  (w_cr_sel),
      .pix (w_pix)
   );

   // The counter wraps to 0 after pixel 63, so every block starts at (0,0)
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt       <= 6'd0;
         r_pix_valid <= 1'b0;
         r_pix       <= '0;
         r_row       <= 3'd0;
         r_col       <= 3'd0;
         r_last      <= 1'b0;
      end else if (w_advance) begin
         r_cnt       <= r_cnt + 6'd1;
         r_pix_valid <= 1'b1;
         r_pix       <= w_pix;
         r_row       <= r_cnt[5:3];
         r_col       <= r_cnt[2:0];
         r_last      <= &r_cnt;
      end else if (pix_ready) begin
         r_pix_valid <= 1'b0;
      end
   end

   assign pix_valid = r_pix_valid;
   assign pix_r     = r_pix.r;
   assign pix_g     = r_pix.g;
   assign pix_b     = r_pix.b;
   assign pix_row   = r_row;
   assign pix_col   = r_col;
   assign pix_last  = r_last;

endmodule
`default_nettype wire
